// File: rtl/hex_digit_serializer_pkg.sv
// Shared definitions for the hex digit serializer: FSM state encoding and digit-count helper.
package hex_digit_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   function automatic int digit_count(input int dw, input int digit_bits);
      return (32'sd1 << dw) >>> $clog2(digit_bits);
   endfunction

endpackage

// File: rtl/hex_digit_serializer_div.sv
// Power-of-two divider: Q = I / 2**S and R = I mod 2**S, built from a shift and a mask.
module shift_divider #(
   parameter int DW = 4
) (
   input  logic [(2**DW)-1:0] I,
   input  logic [DW-1:0]      S,
   output logic [(2**DW)-1:0] Q,
   output logic [(2**DW)-1:0] R
);

   localparam int W = 2**DW;

   logic [W-1:0] mask_s;

   // Quotient and remainder from a right shift and a low-bit mask
   always_comb begin
      mask_s = ~({W{1'b1}} << S);
      Q      = I >> S;
      R      = I & mask_s;
   end

endmodule

// File: rtl/hex_digit_serializer.sv
// Captures a value on start and streams it out one digit per handshake, least-significant first.
module hex_digit_serializer
   import hex_digit_serializer_pkg::*;
#(
   parameter int DW         = 4,
   parameter int DIGIT_BITS = 4,
   parameter int EARLY_STOP = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [(2**DW)-1:0]    value,
   output logic                  busy,
   output logic                  digit_valid,
   input  logic                  digit_ready,
   output logic [DIGIT_BITS-1:0] digit,
   output logic [DW-1:0]         digit_idx,
   output logic                  last,
   output logic                  done
);

   localparam int             W        = 2**DW;
   localparam int             ND       = digit_count(DW, DIGIT_BITS);
   localparam logic [DW-1:0]  LAST_IDX = DW'(ND - 1);
   localparam logic [DW-1:0]  IDX_ONE  = DW'(1);
   localparam logic [DW-1:0]  SHIFT    = DW'(DIGIT_BITS);

   state_e        state_q, state_d;
   logic [W-1:0]  work_q, work_d;
   logic [DW-1:0] idx_q, idx_d;
   logic          done_q, done_d;
   logic [W-1:0]  q, r;
   logic          emit_s;
   logic          last_s;

   shift_divider #(.DW(DW)) u_div (
      .I (work_q),
      .S (SHIFT),
      .Q (q),
      .R (r)
   );

   // Output decode from registered work/idx; everything reads 0 outside EMIT
   always_comb begin
      emit_s = (state_q == ST_EMIT);
      last_s = emit_s & ((idx_q == LAST_IDX) | ((EARLY_STOP != 0) & (q == {W{1'b0}})));
      if (emit_s) begin
         digit     = r[DIGIT_BITS-1:0];
         digit_idx = idx_q;
      end else begin
         digit     = {DIGIT_BITS{1'b0}};
         digit_idx = {DW{1'b0}};
      end
      busy        = emit_s;
      digit_valid = emit_s;
      last        = last_s;
      done        = done_q;
   end

   // Next-state: capture on start, advance on handshake, finish after the last digit
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d  = value;
               idx_d   = {DW{1'b0}};
               state_d = ST_EMIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (digit_ready && last_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (digit_ready) begin
               work_d = q;
               idx_d  = idx_q + IDX_ONE;
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, working value, digit index and done pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         work_q  <= {W{1'b0}};
         idx_q   <= {DW{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_hex_digit_serializer.sv
// Directed bench: three serializer configurations driven on the falling edge and sampled there.
module tb_hex_digit_serializer;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   // u0: hex digits, no early stop
   logic        start0, ready0, busy0, dv0, last0, done0;
   logic [15:0] value0;
   logic [3:0]  digit0, idx0;
   // u1: hex digits, early stop
   logic        start1, ready1, busy1, dv1, last1, done1;
   logic [15:0] value1;
   logic [3:0]  digit1, idx1;
   // u2: binary digits, no early stop
   logic        start2, ready2, busy2, dv2, last2, done2;
   logic [15:0] value2;
   logic [0:0]  digit2;
   logic [3:0]  idx2;

   hex_digit_serializer #(.DW(4), .DIGIT_BITS(4), .EARLY_STOP(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .value(value0), .busy(busy0),
      .digit_valid(dv0), .digit_ready(ready0), .digit(digit0), .digit_idx(idx0),
      .last(last0), .done(done0));

   hex_digit_serializer #(.DW(4), .DIGIT_BITS(4), .EARLY_STOP(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .value(value1), .busy(busy1),
      .digit_valid(dv1), .digit_ready(ready1), .digit(digit1), .digit_idx(idx1),
      .last(last1), .done(done1));

   hex_digit_serializer #(.DW(4), .DIGIT_BITS(1), .EARLY_STOP(0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .value(value2), .busy(busy2),
      .digit_valid(dv2), .digit_ready(ready2), .digit(digit2), .digit_idx(idx2),
      .last(last2), .done(done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      value0 = 16'h0000; value1 = 16'h0000; value2 = 16'h0000;
      ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy0, dv0, digit0, idx0, last0, done0} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_u0: got %h expected 000", {busy0, dv0, digit0, idx0, last0, done0});
      end
      n_tests++;
      if ({busy1, dv1, digit1, idx1, last1, done1} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_u1: got %h expected 000", {busy1, dv1, digit1, idx1, last1, done1});
      end
      n_tests++;
      if ({busy2, dv2, digit2, idx2, last2, done2} !== 9'h000) begin
         n_fail++;
         $display("FAIL reset_u2: got %h expected 000", {busy2, dv2, digit2, idx2, last2, done2});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Digits F,2,A,1 on consecutive cycles, then done pulse
   task automatic test_full_length();
      logic [3:0] exp_d [4];
      exp_d = '{4'hF, 4'h2, 4'hA, 4'h1};
      start0 = 1'b1; value0 = 16'h1A2F;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if ({busy0, dv0, digit0, idx0, last0, done0} !== {1'b1, 1'b1, exp_d[k], 4'(k), (k == 3), 1'b0}) begin
            n_fail++;
            $display("FAIL full_digit%0d: got dv=%b d=%h idx=%0d last=%b done=%b expected d=%h idx=%0d",
                     k, dv0, digit0, idx0, last0, done0, exp_d[k], k);
         end
         @(negedge clk);
      end
      n_tests++;
      if ({busy0, dv0, digit0, idx0, last0, done0} !== {1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL full_done: got busy=%b dv=%b d=%h done=%b expected busy=0 dv=0 d=0 done=1",
                  busy0, dv0, digit0, done0);
      end
      @(negedge clk);
      n_tests++;
      if (done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL full_done_pulse: got done=%b expected 0", done0);
      end
   endtask

   // Early stop on 002F, then zero accepted in the done cycle
   task automatic test_early_stop();
      start1 = 1'b1; value1 = 16'h002F;
      @(negedge clk);
      start1 = 1'b0;
      n_tests++;
      if ({dv1, digit1, idx1, last1} !== {1'b1, 4'hF, 4'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL early_d0: got dv=%b d=%h idx=%0d last=%b expected 1 F 0 0", dv1, digit1, idx1, last1);
      end
      @(negedge clk);
      n_tests++;
      if ({dv1, digit1, idx1, last1} !== {1'b1, 4'h2, 4'h1, 1'b1}) begin
         n_fail++;
         $display("FAIL early_d1: got dv=%b d=%h idx=%0d last=%b expected 1 2 1 1", dv1, digit1, idx1, last1);
      end
      @(negedge clk);
      n_tests++;
      if ({done1, busy1, dv1} !== 3'b100) begin
         n_fail++;
         $display("FAIL early_done: got done/busy/dv=%b expected 100", {done1, busy1, dv1});
      end
      start1 = 1'b1; value1 = 16'h0000;
      @(negedge clk);
      start1 = 1'b0;
      n_tests++;
      if ({done1, busy1, dv1, digit1, idx1, last1} !== {1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL zero_digit: got done=%b busy=%b dv=%b d=%h idx=%0d last=%b expected 0 1 1 0 0 1",
                  done1, busy1, dv1, digit1, idx1, last1);
      end
      @(negedge clk);
      n_tests++;
      if ({done1, dv1} !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_done: got done/dv=%b expected 10", {done1, dv1});
      end
      @(negedge clk);
   endtask

   // Backpressure for three cycles while idx=1
   task automatic test_backpressure();
      logic [3:0] exp_d  [8];
      logic [3:0] exp_i  [8];
      logic       rdy    [8];
      exp_d = '{4'hF, 4'h2, 4'h2, 4'h2, 4'h2, 4'hA, 4'h1, 4'h0};
      exp_i = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h0};
      rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      start0 = 1'b1; value0 = 16'h1A2F;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 7; k++) begin
         n_tests++;
         if ({dv0, digit0, idx0, last0} !== {1'b1, exp_d[k], exp_i[k], (k == 6)}) begin
            n_fail++;
            $display("FAIL bp_cycle%0d: got dv=%b d=%h idx=%0d last=%b expected d=%h idx=%0d",
                     k, dv0, digit0, idx0, last0, exp_d[k], exp_i[k]);
         end
         ready0 = rdy[k];
         @(negedge clk);
      end
      n_tests++;
      if ({done0, dv0} !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_done: got done/dv=%b expected 10", {done0, dv0});
      end
      ready0 = 1'b1;
      @(negedge clk);
   endtask

   // Start while busy is ignored; back-to-back start in the done cycle
   task automatic test_back_to_back();
      logic [3:0] exp_a [4];
      logic [3:0] exp_b [4];
      exp_a = '{4'hF, 4'h2, 4'hA, 4'h1};
      exp_b = '{4'h4, 4'h3, 4'h2, 4'h1};
      start0 = 1'b1; value0 = 16'h1A2F;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         start0 = (k < 2); value0 = 16'hFFFF;
         n_tests++;
         if ({dv0, digit0, idx0} !== {1'b1, exp_a[k], 4'(k)}) begin
            n_fail++;
            $display("FAIL busy_ignore%0d: got dv=%b d=%h idx=%0d expected d=%h idx=%0d",
                     k, dv0, digit0, idx0, exp_a[k], k);
         end
         @(negedge clk);
      end
      n_tests++;
      if ({done0, busy0} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_done: got done/busy=%b expected 10", {done0, busy0});
      end
      start0 = 1'b1; value0 = 16'h1234;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if ({done0, dv0, digit0, idx0} !== {1'b0, 1'b1, exp_b[k], 4'(k)}) begin
            n_fail++;
            $display("FAIL b2b_digit%0d: got done=%b dv=%b d=%h idx=%0d expected d=%h idx=%0d",
                     k, done0, dv0, digit0, idx0, exp_b[k], k);
         end
         @(negedge clk);
      end
      n_tests++;
      if (done0 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done2: got done=%b expected 1", done0);
      end
      @(negedge clk);
   endtask

   // Reset mid-stream aborts without a done pulse
   task automatic test_reset_abort();
      start1 = 1'b1; value1 = 16'h1A2F;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({dv1, digit1, idx1} !== {1'b1, 4'hA, 4'h2}) begin
         n_fail++;
         $display("FAIL abort_pre: got dv=%b d=%h idx=%0d expected 1 A 2", dv1, digit1, idx1);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy1, dv1, digit1, idx1, last1, done1} !== 12'h000) begin
         n_fail++;
         $display("FAIL abort_async: got %h expected 000", {busy1, dv1, digit1, idx1, last1, done1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_tests++;
         if ({done1, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_no_done%0d: got done/busy=%b expected 00", k, {done1, busy1});
         end
      end
      start1 = 1'b1; value1 = 16'h0007;
      @(negedge clk);
      start1 = 1'b0;
      n_tests++;
      if ({dv1, digit1, idx1, last1} !== {1'b1, 4'h7, 4'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL after_reset: got dv=%b d=%h idx=%0d last=%b expected 1 7 0 1", dv1, digit1, idx1, last1);
      end
      repeat (2) @(negedge clk);
   endtask

   // Binary digits of 8001: 1, fourteen zeros, 1
   task automatic test_binary();
      start2 = 1'b1; value2 = 16'h8001;
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         n_tests++;
         if ({dv2, digit2, idx2, last2} !== {1'b1, ((k == 0) || (k == 15)), 4'(k), (k == 15)}) begin
            n_fail++;
            $display("FAIL bin_digit%0d: got dv=%b d=%b idx=%0d last=%b", k, dv2, digit2, idx2, last2);
         end
         @(negedge clk);
      end
      n_tests++;
      if ({done2, dv2} !== 2'b10) begin
         n_fail++;
         $display("FAIL bin_done: got done/dv=%b expected 10", {done2, dv2});
      end
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      @(negedge clk);
      test_reset();
      test_full_length();
      test_early_stop();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_binary();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
